// File: rtl/elastic_fifo_op_pkg.sv
// Shared widths, defaults and req/ack timing constants for the elastic FIFO operator.
package elastic_fifo_op_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    // Handshake timing shared with the producer/consumer/async_operator benches (cycles).
    localparam int unsigned REQ_RISE_CYCLES   = 1;
    localparam int unsigned UPSTREAM_PERIOD   = 3;
    localparam int unsigned DOWNSTREAM_PERIOD = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_fifo_op_if.sv
// Upstream req/ack, downstream req/ack and status bundle of the elastic FIFO operator.
interface elastic_fifo_op_if
    import elastic_fifo_op_pkg::*;
#(
    parameter int unsigned data_width  = DEFAULT_DATA_WIDTH,
    parameter int unsigned depth       = DEFAULT_DEPTH,
    parameter int unsigned output_size = 1
);
    localparam int unsigned CNT_W = cnt_width(depth);

    logic                   req_l;
    logic                   ack_l;
    logic [data_width-1:0]  din;
    logic [output_size-1:0] req_r;
    logic                   ack_r;
    logic [data_width-1:0]  dout;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   err;

    // FIFO side
    modport slave (
        output req_l, ack_r, dout, count, full, empty, err,
        input  ack_l, din, req_r
    );

    // Producer/consumer side
    modport master (
        input  req_l, ack_r, dout, count, full, empty, err,
        output ack_l, din, req_r
    );
endinterface

// File: rtl/elastic_fifo_mem.sv
// Token storage: sync write, combinational read.
module elastic_fifo_mem
    import elastic_fifo_op_pkg::*;
#(
    parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
    parameter int unsigned depth      = DEFAULT_DEPTH
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ptr_width(depth)-1:0]    waddr,
    input  logic [data_width-1:0]          wdata,
    input  logic [ptr_width(depth)-1:0]    raddr,
    output logic [data_width-1:0]          rdata
);
    logic [data_width-1:0] mem_q [depth];
    logic [data_width-1:0] mem_d [depth];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/elastic_fifo_op.sv
// Buffered req/ack dataflow channel holding up to depth tokens in order.
module elastic_fifo_op
    import elastic_fifo_op_pkg::*;
#(
    parameter int unsigned            data_width    = DEFAULT_DATA_WIDTH,
    parameter int unsigned            depth         = DEFAULT_DEPTH,
    parameter int unsigned            output_size   = 1,
    parameter logic [data_width-1:0]  initial_value = '0
) (
    input logic              clk,
    input logic              rst,
    elastic_fifo_op_if.slave io
);
    localparam int unsigned PTR_W = ptr_width(depth);
    localparam int unsigned CNT_W = cnt_width(depth);

    logic                  req_l_q, req_l_d;
    logic                  ack_r_q, ack_r_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  err_q, err_d;

    logic                  push_c;
    logic                  pop_c;
    logic [data_width-1:0] rdata;

    elastic_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (io.din),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // An ack is only accepted against our own outstanding request; anything else is a violation.
    always_comb begin
        push_c   = io.ack_l & req_l_q & ~full_q;
        pop_c    = ~ack_r_q & ~empty_q & (&io.req_r);

        req_l_d  = req_l_q;
        if (io.ack_l) begin
            req_l_d = 1'b0;
        end else if (!req_l_q && (count_q < CNT_W'(depth))) begin
            req_l_d = 1'b1;
        end

        ack_r_d  = pop_c;
        dout_d   = pop_c ? rdata : dout_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        full_d   = (count_d == CNT_W'(depth));
        empty_d  = (count_d == '0);
        err_d    = err_q | (io.ack_l & (~req_l_q | full_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q  <= 1'b0;
            ack_r_q  <= 1'b0;
            dout_q   <= initial_value;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            req_l_q  <= req_l_d;
            ack_r_q  <= ack_r_d;
            dout_q   <= dout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            err_q    <= err_d;
        end
    end

    assign io.req_l = req_l_q;
    assign io.ack_r = ack_r_q;
    assign io.dout  = dout_q;
    assign io.count = count_q;
    assign io.full  = full_q;
    assign io.empty = empty_q;
    assign io.err   = err_q;
endmodule

// File: tb/tb_elastic_fifo_op.sv
// Scoreboard bench for elastic_fifo_op: depth 4, two downstream consumers.
module tb_elastic_fifo_op;
    import elastic_fifo_op_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OSZ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    elastic_fifo_op_if #(.data_width(DW), .depth(DEPTH), .output_size(OSZ)) io ();

    elastic_fifo_op #(
        .data_width    (DW),
        .depth         (DEPTH),
        .output_size   (OSZ),
        .initial_value ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acks     = 0;
    int last_ack = -1;
    bit prev_ack = 1'b0;
    bit gap_chk  = 1'b0;
    bit prod_en  = 1'b0;
    logic [DW-1:0] send_q [$];
    logic [DW-1:0] exp_q  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    // One clock: score any output token, then let the producer model respond.
    task automatic tick();
        logic [DW-1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (io.ack_r === 1'b1) begin
            acks++;
            if (prev_ack) check_eq("ack_consecutive", 1, 0);
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("dout", io.dout, e);
            end
            if (gap_chk && last_ack >= 0) check_eq("ack_gap", 32'(cyc - last_ack), DOWNSTREAM_PERIOD);
            last_ack = cyc;
        end
        prev_ack = (io.ack_r === 1'b1);
        if (prod_en) begin
            if (io.ack_l) begin
                io.ack_l = 1'b0;
            end else if (io.req_l && send_q.size() > 0) begin
                e = send_q.pop_front();
                io.din   = e;
                io.ack_l = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        int a0;
        io.ack_l = 1'b0;
        io.din   = '0;
        io.req_r = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_req_l", io.req_l, 0);
        check_eq("rst_ack_r", io.ack_r, 0);
        check_eq("rst_dout", io.dout, 0);
        check_eq("rst_count", io.count, 0);
        check_eq("rst_empty", io.empty, 1);
        check_eq("rst_full", io.full, 0);
        check_eq("rst_err", io.err, 0);
        rst = 1'b0;
        for (int i = 0; i < int'(REQ_RISE_CYCLES); i++) tick();
        check_eq("req_after_rst", io.req_l, 1);

        // Three tokens buffered with consumer idle, then drained in order
        prod_en = 1'b1;
        send_q = '{32'd10, 32'd11, 32'd12};
        for (int i = 0; i < 40 && io.count != 3'd3; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check_eq("p2_count", io.count, 3);
        check_eq("p2_no_ack", 32'(acks), 0);
        io.req_r = 2'b11;
        gap_chk  = 1'b1;
        last_ack = -1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check_eq("p2_drained", 32'(exp_q.size()), 0);
        check_eq("p2_acks", 32'(acks), 3);
        gap_chk = 1'b0;
        tick();
        check_eq("p2_empty", io.empty, 1);

        // Fill to depth; pop frees a slot and req_l rises on the following edge
        io.req_r = 2'b00;
        send_q = '{32'd0, 32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 40 && io.count != 3'd4; i++) tick();
        check_eq("p3_count", io.count, 4);
        check_eq("p3_full", io.full, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("p3_req_held", io.req_l, 0);
        end
        send_q.push_back(32'd4);
        io.req_r = 2'b11;
        a0 = acks;
        for (int i = 0; i < 20 && acks == a0; i++) tick();
        check_eq("p3_pop", 32'(acks - a0), 1);
        tick();
        check_eq("p3_req_rise", io.req_l, 1);
        for (int i = 0; i < 60 && (send_q.size() > 0 || exp_q.size() > 0); i++) tick();
        check_eq("p3_drained", 32'(send_q.size() + exp_q.size()), 0);
        check_eq("p3_err", io.err, 0);

        // Ack while full: token dropped, sticky err
        io.req_r = 2'b00;
        send_q = '{32'd20, 32'd21, 32'd22, 32'd23};
        for (int i = 0; i < 40 && io.count != 3'd4; i++) tick();
        prod_en  = 1'b0;
        io.din   = 32'd99;
        io.ack_l = 1'b1;
        tick();
        io.ack_l = 1'b0;
        check_eq("p4_err", io.err, 1);
        check_eq("p4_count", io.count, 4);
        tick();
        tick();
        check_eq("p4_err_sticky", io.err, 1);
        io.req_r = 2'b11;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        tick();
        check_eq("p4_drained", 32'(exp_q.size()), 0);
        check_eq("p4_count_end", io.count, 0);
        check_eq("p4_err_end", io.err, 1);

        // Partial downstream request must not pop
        prod_en  = 1'b1;
        io.req_r = 2'b01;
        send_q = '{32'd30, 32'd31};
        for (int i = 0; i < 40 && io.count != 3'd2; i++) tick();
        a0 = acks;
        for (int i = 0; i < 10; i++) tick();
        check_eq("p5_no_ack", 32'(acks - a0), 0);
        check_eq("p5_count", io.count, 2);
        io.req_r = 2'b11;
        for (int i = 0; i < 10 && acks == a0; i++) tick();
        io.req_r = 2'b00;
        check_eq("p5_count_pop", io.count, 1);
        tick();
        tick();
        check_eq("p5_one_ack", 32'(acks - a0), 1);

        // Reset mid-stream with an in-flight ack
        send_q = '{32'd32, 32'd33};
        for (int i = 0; i < 40 && io.count != 3'd3; i++) tick();
        check_eq("p6_count", io.count, 3);
        prod_en  = 1'b0;
        rst      = 1'b1;
        io.din   = 32'd77;
        io.ack_l = 1'b1;
        tick();
        check_eq("p6_rst_count", io.count, 0);
        check_eq("p6_rst_empty", io.empty, 1);
        check_eq("p6_rst_dout", io.dout, 0);
        check_eq("p6_rst_req", io.req_l, 0);
        check_eq("p6_rst_err", io.err, 0);
        rst      = 1'b0;
        io.ack_l = 1'b0;
        send_q.delete();
        exp_q.delete();
        tick();
        check_eq("p6_req_restart", io.req_l, 1);
        check_eq("p6_count_after", io.count, 0);

        // Long in-order stream
        for (int i = 0; i < 5000; i++) send_q.push_back($urandom());
        a0       = acks;
        prod_en  = 1'b1;
        io.req_r = 2'b11;
        for (int i = 0; i < 5000 * int'(UPSTREAM_PERIOD) * 2 && (send_q.size() > 0 || exp_q.size() > 0); i++) tick();
        check_eq("stream_left", 32'(send_q.size() + exp_q.size()), 0);
        check_eq("stream_acks", 32'(acks - a0), 5000);
        tick();
        check_eq("stream_empty", io.empty, 1);
        check_eq("stream_err", io.err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
